// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue merging LSU and ALU results into one register-file write port, with youngest-entry bypass lookup.
module wb_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_rd_i,
  input  logic [DATA_WIDTH-1:0]   lsu_data_i,
  output logic                    lsu_ready_o,
  input  logic                    alu_valid_i,
  input  logic [ADDR_WIDTH-1:0]   alu_rd_i,
  input  logic [DATA_WIDTH-1:0]   alu_data_i,
  output logic                    alu_ready_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   rw_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic [ADDR_WIDTH-1:0]   ra_i,
  input  logic [ADDR_WIDTH-1:0]   rb_i,
  output logic                    hit_a_o,
  output logic                    hit_b_o,
  output logic [DATA_WIDTH-1:0]   byp_a_o,
  output logic [DATA_WIDTH-1:0]   byp_b_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_space, w_need;
  logic                  w_pop, w_lsu_push, w_alu_push;
  logic [PW-1:0]         w_alu_slot;
  // The head slot drains every cycle it is occupied, so it counts as free space.
  assign w_pop       = r_count != '0;
  assign w_space     = CW'(DEPTH) - r_count + CW'(w_pop);
  assign w_need      = (lsu_valid_i && lsu_rd_i != '0) ? CW'(2) : CW'(1);
  assign lsu_ready_o = w_space >= CW'(1);
  assign alu_ready_o = w_space >= w_need;
  assign w_lsu_push  = lsu_valid_i && lsu_ready_o && lsu_rd_i != '0;
  assign w_alu_push  = alu_valid_i && alu_ready_o && alu_rd_i != '0;
  assign w_alu_slot  = r_tail + PW'(w_lsu_push);
  assign we_o        = w_pop;
  assign rw_o        = r_rd[r_head];
  assign wdata_o     = r_data[r_head];
  assign count_o     = r_count;
  // Walk from oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit_a_o = 1'b0;
    hit_b_o = 1'b0;
    byp_a_o = '0;
    byp_b_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if (ra_i != '0 && r_rd[r_head + PW'(i)] == ra_i) begin
          hit_a_o = 1'b1;
          byp_a_o = r_data[r_head + PW'(i)];
        end
        if (rb_i != '0 && r_rd[r_head + PW'(i)] == rb_i) begin
          hit_b_o = 1'b1;
          byp_b_o = r_data[r_head + PW'(i)];
        end
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_lsu_push) begin
        r_rd[r_tail]   <= lsu_rd_i;
        r_data[r_tail] <= lsu_data_i;
      end
      if (w_alu_push) begin
        r_rd[w_alu_slot]   <= alu_rd_i;
        r_data[w_alu_slot] <= alu_data_i;
      end
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_lsu_push) + PW'(w_alu_push);
      r_count <= r_count + CW'(w_lsu_push) + CW'(w_alu_push) - CW'(w_pop);
    end
  end
endmodule
